duty_ramp: RTL and testbench
============================

DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` is the single clock and `rst` is the reset.
REQ-002 Parameter `STEP_DIV`, default 256, SHALL set the number of `clk` cycles per ramp step (256 equals one 8-bit PWM period); legal values are 2 to 65535.
REQ-003 Parameter `STEP_SIZE`, default 1, SHALL set the duty increment or decrement per step; legal values are 1 to 255.
REQ-004 Parameter `MAX_DUTY`, default 240, SHALL set the clamp ceiling; it is used only when the clamp feature is compiled in.
REQ-005 `clk`, input, 1 bit: rising-edge clock.
REQ-006 `rst`, input, 1 bit: synchronous, active-high reset.
REQ-007 `target_duty`, input, 8 bits: requested final duty value.
REQ-008 `target_valid`, input, 1 bit: `target_duty` is valid this cycle.
REQ-009 `target_ready`, output, 1 bit: the block accepts a new target this cycle.
REQ-010 `abort`, input, 1 bit: emergency ramp-down to zero.
REQ-011 `duty_cycle`, output, 8 bits: registered duty value fed directly to the PWM generator's `duty_cycle` input.
REQ-012 `busy`, output, 1 bit: a ramp is in progress.
REQ-013 `done`, output, 1 bit: single-cycle pulse when `duty_cycle` reaches the accepted target.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RAMP_UP and RAMP_DOWN.
REQ-015 `target_ready` SHALL equal (state == IDLE) && !`abort`, with no register stage.
REQ-016 Acceptance occurs on a cycle where `target_valid` && `target_ready` are both high; on acceptance the block SHALL latch the effective target into `tgt_q` and clear the step timer.
  - If the target is greater than `duty_cycle`: next state RAMP_UP.
  - If the target is less than `duty_cycle`: next state RAMP_DOWN.
  - If the target equals `duty_cycle`: stay in IDLE and pulse `done` on the next cycle.
REQ-017 The step timer SHALL count 0 to `STEP_DIV`-1 only while in RAMP_UP or RAMP_DOWN.
  - A step fires when the count equals `STEP_DIV`-1; the count then wraps to 0.
  - The first `duty_cycle` change SHALL occur exactly `STEP_DIV` cycles after the acceptance edge.
REQ-018 Each step in RAMP_UP SHALL set `duty_cycle` to min(`duty_cycle` + `STEP_SIZE`, `tgt_q`).
  - The compare SHALL use 9-bit arithmetic so there is no 8-bit wrap and no overshoot.
REQ-019 Each step in RAMP_DOWN SHALL set `duty_cycle` to max(`duty_cycle` - `STEP_SIZE`, `tgt_q`).
  - The compare SHALL use 9-bit signed arithmetic so there is no underflow.
REQ-020 On the step that makes `duty_cycle` equal `tgt_q`, the FSM SHALL return to IDLE and `done` SHALL be high for exactly the following single cycle.
REQ-021 `busy` SHALL be high exactly when the state is RAMP_UP or RAMP_DOWN.
REQ-022 `duty_cycle` SHALL change only on step edges or on abort; it SHALL never change by more than `STEP_SIZE` per step.
REQ-023 When `abort` is high in any state, the block SHALL respond on the next edge:
  - set `tgt_q` to 0;
  - set the state to RAMP_DOWN, or to IDLE if `duty_cycle` is already 0;
  - clear the step timer;
  - leave `duty_cycle` unchanged (it ramps down at the normal step rate).
REQ-024 When `abort` and `target_valid` are both high in the same cycle, `abort` SHALL win and the target SHALL NOT be accepted.
REQ-025 An abort that completes SHALL pulse `done` exactly as a normal ramp does.
REQ-026 `target_duty` SHALL be ignored outside acceptance cycles.

Reset
REQ-027 While `rst` is high at a clock edge, the block SHALL force:
  - state IDLE;
  - `duty_cycle` = 0;
  - `tgt_q` = 0;
  - step timer = 0;
  - `done` = 0 and `busy` = 0.
REQ-028 `target_ready` SHALL read 1 in the first cycle after reset when `abort` is low.
REQ-029 A reset asserted mid-ramp SHALL take priority over every other input and SHALL discard the ramp with no `done` pulse.

Configuration
REQ-030 The clamp feature SHALL be controlled by the macro `DUTY_RAMP_CLAMP_EN`.
  - When defined: the effective target is min(`target_duty`, `MAX_DUTY`), applied at acceptance.
  - When undefined: the effective target is `target_duty`, the full range 0 to 255 is available, and `MAX_DUTY` is unused.

Structure
REQ-031 The package `duty_ramp_pkg` SHALL hold:
  - the state enum (IDLE, RAMP_UP, RAMP_DOWN);
  - `DUTY_W` = 8;
  - the default constants for `STEP_DIV`, `STEP_SIZE` and `MAX_DUTY`.
REQ-032 The step timer SHALL be a separate sub-module, `step_timer`, with ports `clk`, `rst`, `en` and `clr`, parameter `DIV`, and output `tick`.

Verification
All scenarios use `STEP_DIV`=4 and `STEP_SIZE`=16 unless stated otherwise.
REQ-033 Reset then idle: `rst` held for 2 cycles, then released -> `duty_cycle`=0, `busy`=0, `target_ready`=1, `done`=0.
REQ-034 Ramp up: accept target 64 from 0 -> `duty_cycle` steps 16, 32, 48, 64 at acceptance+4, +8, +12 and +16 cycles; a single `done` pulse follows; `busy` falls together with the state returning to IDLE.
REQ-035 Down with no overshoot: `STEP_SIZE`=50, start at 128, accept target 20 -> `duty_cycle` goes 78, then 28, then 20; it never goes below 20.
REQ-036 Abort mid-ramp: abort while ramping 0 to 192 at `duty_cycle`=96, with `target_valid` also high -> target not accepted; `duty_cycle` then steps 80, 64, ..., 0; a single `done` pulse follows.
REQ-037 Equal target and reset mid-ramp:
  - Accept target equal to `duty_cycle` -> `done` pulses the next cycle and `busy` stays 0.
  - Assert `rst` mid-ramp -> `duty_cycle`=0 and no `done` pulse.
REQ-038 Clamp: with `DUTY_RAMP_CLAMP_EN` defined and `MAX_DUTY`=240, target 255 -> final `duty_cycle`=240. With the macro undefined, target 255 -> final `duty_cycle`=255.

Source files
------------

// File: rtl/duty_ramp_pkg.sv
// Shared types and default constants for the duty_ramp soft-start controller.
package duty_ramp_pkg;

    localparam int DUTY_W        = 8;
    localparam int STEP_DIV_DEF  = 256;
    localparam int STEP_SIZE_DEF = 1;
    localparam int MAX_DUTY_DEF  = 240;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/step_timer.sv
// Free-running divider that pulses tick once every DIV enabled cycles.
module step_timer
    import duty_ramp_pkg::*;
#(
    parameter int DIV = STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // A clear on the same cycle suppresses the tick so a restart is always a full period.
        tick  = en && !clr && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/duty_ramp.sv
// PWM duty soft-start/soft-stop ramp with abort. Define DUTY_RAMP_CLAMP_EN to
// clamp accepted targets to MAX_DUTY.
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int STEP_DIV  = STEP_DIV_DEF,
    parameter int STEP_SIZE = STEP_SIZE_DEF,
    parameter int MAX_DUTY  = MAX_DUTY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              busy,
    output logic              done
);

    if (STEP_DIV < 2 || STEP_DIV > 65535 || STEP_SIZE < 1 || STEP_SIZE > 255 ||
        MAX_DUTY < 0 || MAX_DUTY > 255) begin : g_bad_param
        $error("duty_ramp: parameter out of range");
    end

    localparam logic [DUTY_W:0] STEP9 = (DUTY_W+1)'(STEP_SIZE);

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [DUTY_W-1:0]   tgt_q, tgt_d;
    logic                done_q, done_d;
    logic [DUTY_W-1:0]   eff_tgt;
    logic                accept, tick, tmr_clr;
    logic [DUTY_W:0]     up_sum;
    logic signed [DUTY_W:0] dn_diff;

`ifdef DUTY_RAMP_CLAMP_EN
    localparam logic [DUTY_W-1:0] MAX_D = DUTY_W'(MAX_DUTY);
    assign eff_tgt = (target_duty > MAX_D) ? MAX_D : target_duty;
`else
    assign eff_tgt = target_duty;
`endif

    // Extra bit keeps the step compare free of wrap in both directions.
    assign up_sum  = {1'b0, duty_q} + STEP9;
    assign dn_diff = $signed({1'b0, duty_q}) - $signed(STEP9);

    step_timer #(.DIV(STEP_DIV)) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .clr  (tmr_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        if (abort) begin
            tgt_d   = '0;
            state_d = (duty_q == '0) ? IDLE : RAMP_DOWN;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tgt_d = eff_tgt;
                        if (eff_tgt > duty_q)      state_d = RAMP_UP;
                        else if (eff_tgt < duty_q) state_d = RAMP_DOWN;
                        else                       done_d  = 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (tick) begin
                        if (up_sum >= {1'b0, tgt_q}) begin
                            duty_d  = tgt_q;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            duty_d = up_sum[DUTY_W-1:0];
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (tick) begin
                        if (dn_diff <= $signed({1'b0, tgt_q})) begin
                            duty_d  = tgt_q;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            duty_d = dn_diff[DUTY_W-1:0];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
        target_ready = (state_q == IDLE) && !abort;
        accept       = target_valid && target_ready;
        tmr_clr      = accept || abort;
        duty_cycle   = duty_q;
        done         = done_q;
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Scoreboard bench for duty_ramp: two instances (STEP_SIZE 16 and 50, STEP_DIV 4).
module tb_duty_ramp;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] td0, td1;
    logic       tv0, tv1, ab0, ab1;
    logic       rdy0, rdy1, busy0, busy1, done0, done1;
    logic [7:0] duty0, duty1;

    always #5 clk = ~clk;

    duty_ramp #(.STEP_DIV(4), .STEP_SIZE(16), .MAX_DUTY(240)) u_dut0 (
        .clk(clk), .rst(rst), .target_duty(td0), .target_valid(tv0),
        .target_ready(rdy0), .abort(ab0), .duty_cycle(duty0), .busy(busy0), .done(done0)
    );

    duty_ramp #(.STEP_DIV(4), .STEP_SIZE(50), .MAX_DUTY(240)) u_dut1 (
        .clk(clk), .rst(rst), .target_duty(td1), .target_valid(tv1),
        .target_ready(rdy1), .abort(ab1), .duty_cycle(duty1), .busy(busy1), .done(done1)
    );

    typedef struct {
        bit       is_done;
        bit [7:0] val;
        int       cyc;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    logic [7:0] prev0 = 8'd0;
    logic [7:0] prev1 = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int d, bit dn, int v, int c);
        ev_t e;
        e.is_done = dn;
        e.val     = v[7:0];
        e.cyc     = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic got(int d, bit dn, logic [7:0] v);
        ev_t e;
        bit  empty;
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL dut%0d_unexpected: got %s val=%0d at cyc %0d, expected no event",
                     d, dn ? "done" : "duty", v, cyc);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.is_done != dn || (!dn && e.val != v) || e.cyc != cyc) begin
            errors++;
            $display("FAIL dut%0d_event: got %s val=%0d cyc=%0d, expected %s val=%0d cyc=%0d",
                     d, dn ? "done" : "duty", v, cyc,
                     e.is_done ? "done" : "duty", e.val, e.cyc);
        end
    endtask

    // Monitor: every duty change and every cycle of done high is an event.
    always @(negedge clk) begin
        if (duty0 !== prev0) begin got(0, 1'b0, duty0); prev0 = duty0; end
        if (done0 === 1'b1) got(0, 1'b1, 8'd0);
        if (duty1 !== prev1) begin got(1, 1'b0, duty1); prev1 = duty1; end
        if (done1 === 1'b1) got(1, 1'b1, 8'd0);
    end

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic accept(int d, logic [7:0] val, output int acc);
        @(negedge clk);
        if (d == 0) begin td0 = val; tv0 = 1'b1; end
        else        begin td1 = val; tv1 = 1'b1; end
        @(posedge clk);
        #1;
        acc = cyc;
        tv0 = 1'b0;
        tv1 = 1'b0;
        td0 = 8'hA5;
        td1 = 8'h5A;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, ab, fin, n, v;
        rst = 1'b1;
        td0 = 8'h00; td1 = 8'h00;
        tv0 = 1'b0;  tv1 = 1'b0;
        ab0 = 1'b0;  ab1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_duty", duty0, 0);
        check("reset_busy", busy0, 0);
        check("reset_ready", rdy0, 1);
        check("reset_done", done0, 0);

        // Ramp up 0 -> 64
        accept(0, 8'd64, acc);
        check("up_busy_start", busy0, 1);
        for (int i = 1; i <= 4; i++) push(0, 1'b0, 16 * i, acc + 4 * i);
        push(0, 1'b1, 0, acc + 16);
        wait_until(acc + 15);
        check("up_busy_before_end", busy0, 1);
        @(negedge clk);
        check("up_busy_end", busy0, 0);
        check("up_ready_end", rdy0, 1);

        // Equal target: done next cycle, never busy
        accept(0, 8'd64, acc);
        push(0, 1'b1, 0, acc);
        @(negedge clk);
        check("eq_busy", busy0, 0);

        // Reset mid-ramp: discard, no done
        accept(0, 8'd192, acc);
        push(0, 1'b0, 80, acc + 4);
        wait_until(acc + 6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push(0, 1'b0, 0, cyc);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_duty", duty0, 0);
        check("rst_mid_ready", rdy0, 1);
        repeat (4) @(negedge clk);

        // Abort mid-ramp at 96 with a competing target
        accept(0, 8'd192, acc);
        for (int i = 1; i <= 6; i++) push(0, 1'b0, 16 * i, acc + 4 * i);
        wait_until(acc + 24);
        ab0 = 1'b1; tv0 = 1'b1; td0 = 8'd200;
        #1;
        check("abort_ready_low", rdy0, 0);
        @(posedge clk);
        #1;
        ab = cyc;
        ab0 = 1'b0; tv0 = 1'b0;
        check("abort_busy", busy0, 1);
        for (int i = 1; i <= 6; i++) push(0, 1'b0, 96 - 16 * i, ab + 4 * i);
        push(0, 1'b1, 0, ab + 24);
        wait_until(ab + 26);
        check("abort_end_busy", busy0, 0);

        // STEP_SIZE 50: up to 128, then down to 20 without overshoot
        accept(1, 8'd128, acc);
        push(1, 1'b0, 50, acc + 4);
        push(1, 1'b0, 100, acc + 8);
        push(1, 1'b0, 128, acc + 12);
        push(1, 1'b1, 0, acc + 12);
        wait_until(acc + 14);
        accept(1, 8'd20, acc);
        push(1, 1'b0, 78, acc + 4);
        push(1, 1'b0, 28, acc + 8);
        push(1, 1'b0, 20, acc + 12);
        push(1, 1'b1, 0, acc + 12);
        wait_until(acc + 14);
        check("dn50_final", duty1, 20);

        // Target 255: clamped to MAX_DUTY only when the clamp is compiled in
`ifdef DUTY_RAMP_CLAMP_EN
        fin = 240;
`else
        fin = 255;
`endif
        n = (fin + 15) / 16;
        accept(0, 8'd255, acc);
        for (int i = 1; i <= n; i++) begin
            v = 16 * i;
            if (v > fin) v = fin;
            push(0, 1'b0, v, acc + 4 * i);
        end
        push(0, 1'b1, 0, acc + 4 * n);
        wait_until(acc + 4 * n + 2);
        check("clamp_final", duty0, fin);

        repeat (8) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
